// File: rtl/ts_switch_scheduler.sv
`timescale 1ns/1ps
// ts_switch_scheduler: picks which of four sync-recovered TS streams feeds the
// output FIFO mux. Switches land only on a packet start of the new stream.
// Per-stream health comes from sync liveness and windowed error counts, and
// auto mode fails over to the lowest-index healthy stream.
module ts_switch_scheduler #(
  parameter int ERR_W        = 16,
  parameter int WINDOW_PKTS  = 64,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int HOLDOFF_PKTS = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       valid,
  input  logic [3:0]       sync,
  input  logic [3:0]       err_pulse,
  input  logic             cfg_auto,
  input  logic [1:0]       cfg_manual_sel,
  input  logic [ERR_W-1:0] cfg_err_thresh,
  output logic [1:0]       mux_control,
  output logic             switch_pending,
  output logic [3:0]       stream_healthy,
  output logic [15:0]      switch_count
);

  localparam int LIVE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PKT_W  = $clog2(WINDOW_PKTS + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_PKTS + 1);
  localparam logic [LIVE_W-1:0] TIMEOUT_V  = LIVE_W'(TIMEOUT_CYC);
  localparam logic [PKT_W-1:0]  WIN_LAST   = PKT_W'(WINDOW_PKTS - 1);
  localparam logic [HOLD_W-1:0] HOLDOFF_V  = HOLD_W'(HOLDOFF_PKTS);

  typedef enum logic [1:0] {IDLE, WAIT_BOUNDARY, HOLDOFF} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [3:0] pkt;
  assign pkt = sync & valid;

  for (genvar g = 0; g < 4; g++) begin : g_stream
    logic [LIVE_W-1:0] live_cnt;
    logic [PKT_W-1:0]  win_pkts;
    logic [ERR_W-1:0]  win_errs;
    logic              healthy_r;
    logic              alive;
    logic [ERR_W:0]    err_total;

    // The error pulse of the closing cycle still belongs to the closing window.
    assign err_total = {1'b0, win_errs} + {{ERR_W{1'b0}}, err_pulse[g]};
    assign alive     = live_cnt < TIMEOUT_V;
    assign stream_healthy[g] = healthy_r & alive;

    // Cycles since the last packet start, saturating at the timeout.
    always_ff @(posedge clk) begin
      if (!rstn)                     live_cnt <= '0;
      else if (pkt[g])               live_cnt <= '0;
      else if (live_cnt != TIMEOUT_V) live_cnt <= live_cnt + 1'b1;
    end

    // Packet/error window; health verdict is taken when the window closes.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        win_pkts  <= '0;
        win_errs  <= '0;
        healthy_r <= 1'b0;
      end else if (pkt[g] && win_pkts == WIN_LAST) begin
        healthy_r <= err_total < {1'b0, cfg_err_thresh};
        win_pkts  <= '0;
        win_errs  <= '0;
      end else begin
        if (pkt[g]) win_pkts <= win_pkts + 1'b1;
        if (err_pulse[g] && win_errs != '1) win_errs <= win_errs + 1'b1;
      end
    end
  end

  logic [1:0] target;

  // Desired stream: manual select, or keep current / lowest healthy in auto.
  always_comb begin
    target = mux_control;
    if (!cfg_auto) begin
      target = cfg_manual_sel;
    end else if (!stream_healthy[mux_control]) begin
      for (int i = 3; i >= 0; i--) begin
        if (stream_healthy[i]) target = 2'(i);
      end
    end
  end

  state_t            state;
  logic [1:0]        tgt;
  logic [LIVE_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] holdoff_cnt;

  // Switch FSM: arm on a target change, commit on the target's packet start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      tgt            <= '0;
      wait_cnt       <= '0;
      holdoff_cnt    <= '0;
      mux_control    <= '0;
      switch_pending <= 1'b0;
      switch_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (target != mux_control && !(cfg_auto && holdoff_cnt != '0)) begin
            tgt            <= target;
            wait_cnt       <= '0;
            switch_pending <= 1'b1;
            state          <= WAIT_BOUNDARY;
          end
        end
        WAIT_BOUNDARY: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A packet start on the target wins over a coincident timeout.
          if (pkt[tgt]) begin
            mux_control    <= tgt;
            switch_count   <= sat_inc16(switch_count);
            holdoff_cnt    <= HOLDOFF_V;
            switch_pending <= 1'b0;
            state          <= HOLDOFF;
          end else if (wait_cnt == TIMEOUT_V - 1'b1 || target != tgt) begin
            switch_pending <= 1'b0;
            state          <= IDLE;
          end
        end
        HOLDOFF: begin
          // Manual mode never waits out the holdoff; clear it so a later
          // change to auto does not find a stale count.
          if (!cfg_auto) begin
            holdoff_cnt <= '0;
            state       <= IDLE;
          end else if (holdoff_cnt == '0) begin
            state <= IDLE;
          end else if (pkt[mux_control]) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
            if (holdoff_cnt == HOLD_W'(1)) state <= IDLE;
          end
        end
        default: begin
          switch_pending <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
